// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit for the EX stage: a multiply with a fixed latency
// and a radix-2 restoring divide, with valid/ready handshakes on both sides and flush.
module muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_src1,
    input  logic [WIDTH-1:0] in_src2,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             busy
);

    localparam int CNT_MAX = (WIDTH > MUL_STAGES) ? WIDTH : MUL_STAGES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [2:0] OP_MUL   = 3'b000;
    localparam logic [2:0] OP_MULH  = 3'b001;
    localparam logic [2:0] OP_MULHU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b100;
    localparam logic [2:0] OP_MOD   = 3'b101;
    localparam logic [2:0] OP_DIVU  = 3'b110;
    localparam logic [2:0] OP_MODU  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [2*WIDTH-1:0]   mul_b_q, mul_b_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH:0]       rem_q, rem_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic                 qneg_q, qneg_d;
    logic                 rneg_q, rneg_d;
    logic [WIDTH-1:0]     result_q, result_d;

    logic                 in_ready_s;
    logic                 accept_s;
    logic [2*WIDTH-1:0]   mul_prod_s;
    logic [WIDTH+1:0]     shifted_s;
    logic [WIDTH+1:0]     diff_s;
    logic                 div_signed_s;
    logic                 src1_neg_s;
    logic                 src2_neg_s;
    logic [WIDTH-1:0]     q_fix_s;
    logic [WIDTH-1:0]     r_fix_s;

    function automatic logic [WIDTH-1:0] mul_select(input logic [2:0] op,
                                                     input logic [2*WIDTH-1:0] prod);
        logic [WIDTH-1:0] res;
        case (op)
            OP_MUL:   res = prod[WIDTH-1:0];
            OP_MULH:  res = prod[2*WIDTH-1:WIDTH];
            OP_MULHU: res = prod[2*WIDTH-1:WIDTH];
            default:  res = '0;
        endcase
        return res;
    endfunction

    function automatic logic [WIDTH-1:0] div_select(input logic [2:0] op,
                                                     input logic [WIDTH-1:0] q,
                                                     input logic [WIDTH-1:0] r);
        logic [WIDTH-1:0] res;
        case (op)
            OP_DIV:  res = q;
            OP_DIVU: res = q;
            OP_MOD:  res = r;
            OP_MODU: res = r;
            default: res = '0;
        endcase
        return res;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic neg,
                                                    input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] res;
        if (neg) begin
            res = -v;
        end else begin
            res = v;
        end
        return res;
    endfunction

    assign in_ready_s = ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready)) & ~flush;
    assign accept_s   = in_valid & in_ready_s;

    assign mul_prod_s   = mul_a_q * mul_b_q;
    // The remainder stays below the divisor, so the top bit of shifted_s is always clear
    // and diff_s[WIDTH+1] is a clean borrow flag.
    assign shifted_s    = {rem_q, quo_q[WIDTH-1]};
    assign diff_s       = shifted_s - {2'b00, dvs_q};
    assign div_signed_s = (in_op == OP_DIV) | (in_op == OP_MOD);
    assign src1_neg_s   = div_signed_s & in_src1[WIDTH-1];
    assign src2_neg_s   = div_signed_s & in_src2[WIDTH-1];
    assign q_fix_s      = magnitude(qneg_q, quo_q);
    assign r_fix_s      = magnitude(rneg_q, rem_q[WIDTH-1:0]);

    // Next-state and datapath update for the multiply/divide FSM.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_MUL: begin
                    if (cnt_q == '0) begin
                        state_d  = S_DONE;
                        result_d = mul_select(op_q, mul_prod_s);
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_DIV: begin
                    if (diff_s[WIDTH+1]) begin
                        rem_d = shifted_s[WIDTH:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end else begin
                        rem_d = diff_s[WIDTH:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = S_FIX;
                    end else begin
                        state_d = S_DIV;
                    end
                end
                S_FIX: begin
                    state_d  = S_DONE;
                    result_d = div_select(op_q, q_fix_s, r_fix_s);
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // A new op overrides the IDLE/DONE choice above; accept_s already excludes flush.
        if (accept_s) begin
            op_d = in_op;
            case (in_op)
                OP_MUL, OP_MULH: begin
                    mul_a_d = {{WIDTH{in_src1[WIDTH-1]}}, in_src1};
                    mul_b_d = {{WIDTH{in_src2[WIDTH-1]}}, in_src2};
                    cnt_d   = CW'(MUL_STAGES - 1);
                    state_d = S_MUL;
                end
                OP_MULHU: begin
                    mul_a_d = {{WIDTH{1'b0}}, in_src1};
                    mul_b_d = {{WIDTH{1'b0}}, in_src2};
                    cnt_d   = CW'(MUL_STAGES - 1);
                    state_d = S_MUL;
                end
                OP_DIV, OP_MOD, OP_DIVU, OP_MODU: begin
                    if (in_src2 == '0) begin
                        quo_d   = '1;
                        rem_d   = {1'b0, in_src1};
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = S_FIX;
                    end else begin
                        quo_d   = magnitude(src1_neg_s, in_src1);
                        rem_d   = '0;
                        dvs_d   = magnitude(src2_neg_s, in_src2);
                        qneg_d  = src1_neg_s ^ src2_neg_s;
                        rneg_d  = src1_neg_s;
                        cnt_d   = CW'(WIDTH);
                        state_d = S_DIV;
                    end
                end
                default: begin
                    quo_d   = '0;
                    rem_d   = '0;
                    qneg_d  = 1'b0;
                    rneg_d  = 1'b0;
                    state_d = S_FIX;
                end
            endcase
        end else begin
            op_d = op_d;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            op_q     <= 3'b000;
            cnt_q    <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = (state_q == S_DONE);
    assign out_result = result_q;
    assign busy       = (state_q == S_MUL) | (state_q == S_DIV) | (state_q == S_FIX);

endmodule
